mmio_gpio: RTL and testbench
============================

# mmio_gpio

Parametrised memory-mapped GPIO block for the single-cycle core, replacing the fixed 4-LED output block and the fixed switch/IR input block with one unit. It owns a small register window in the data address space and exposes:
- registered outputs;
- synchronised and debounced inputs;
- sticky rising-edge status with write-1-to-clear;
- a maskable interrupt.

Reads outside the window pass data-RAM read data through unchanged, so the block sits directly on the core's load-data path.

## Interface
- ADDR_W, 5, data address width (core ALU result low bits)
- DATA_W, 32, data bus width
- OUT_W, 4, output channel count (1..DATA_W)
- IN_W, 6, input channel count (1..DATA_W)
- BASE, 5'h1C, window base address; must be a multiple of 4
- DEB_CYCLES, 4, consecutive stable cycles required to accept an input change (>=1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr  in  ADDR_W  data address
- we  in  1  store strobe from control unit
- wdata  in  DATA_W  store data
- ram_rdata  in  DATA_W  data-RAM read data
- rdata  out  DATA_W  load data to result mux
- gpio_in  in  IN_W  asynchronous inputs (switches, IR)
- gpio_out  out  OUT_W  output pins (LEDs)
- irq  out  1  interrupt request, level, registered

## Operation
- Register map, offset from BASE (addr[1:0] selects; hit = addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]):
  - 0 OUT: rw, bits [OUT_W-1:0].
  - 1 IN: ro, debounced inputs [IN_W-1:0]; writes ignored.
  - 2 EDGE: sticky rising-edge flags [IN_W-1:0]; writing 1 to a bit clears it, writing 0 has no effect.
  - 3 IRQ_EN: rw mask [IN_W-1:0].
- Unused upper bits read 0 and are ignored on write.
- Read path is combinational:
  - rdata = selected register, zero-extended, when hit.
  - rdata = ram_rdata otherwise.
- Writes occur only when we && hit. Stores outside the window have no effect on this block.
- Input path, per bit:
  - Two-flop synchroniser feeds the debouncer.
  - The debouncer holds deb (the accepted value) and cnt, width $clog2(DEB_CYCLES+1).
  - While sync == deb: cnt = 0.
  - While sync != deb: cnt increments. When cnt == DEB_CYCLES-1, deb <= sync and cnt <= 0.
  - A glitch shorter than DEB_CYCLES cycles never reaches deb.
- Edge detect: EDGE[i] is set on the cycle deb[i] goes 0->1. A set and a W1C on the same bit in the same cycle leave the bit set (set wins).
- irq <= |(EDGE & IRQ_EN), updated every cycle.
- Reset values (reset overrides any write in the same cycle):
  - gpio_out = 0, irq = 0.
  - OUT, EDGE, IRQ_EN = 0.
  - Synchroniser flops = 0, deb = 0, cnt = 0.

## Timing
- Write latency: OUT, IRQ_EN and EDGE change on the clk edge that samples we. gpio_out reflects new OUT in the following cycle.
- Read latency: 0 cycles (same-cycle load, matching the single-cycle core).
- Input latency: a clean step on gpio_in is visible in IN 2 + DEB_CYCLES cycles after the first sampling edge.
  - EDGE sets on the same edge IN updates.
  - irq rises one cycle later.
- Clearing EDGE via W1C drops irq one cycle after the write edge, unless another enabled flag is set.
- Writing IRQ_EN with a pending EDGE bit raises irq one cycle after the write edge.
- Reset asserted mid-debounce discards the pending change; the input is re-qualified from deb = 0 after release.

## Configuration
- MMIO_GPIO_DEBOUNCE_EN defined:
  - Debouncer as above.
  - Input latency 2 + DEB_CYCLES.
- Not defined:
  - Debounce counters are not built; deb = synchroniser output and DEB_CYCLES is ignored.
  - Input latency 2 cycles. Glitches of one sampled cycle do propagate to IN and EDGE.

## Test plan
- Reset: assert reset 2 cycles with we=1, addr=BASE, wdata=F -> gpio_out=0, irq=0, reads of offsets 0..3 return 0.
- Output write/readback: store 32'hFFFF_FFF5 to BASE -> gpio_out=4'h5 next cycle; load BASE returns 32'h5. Store to BASE+1 -> IN unchanged. Store to addr 5'h04 -> gpio_out unchanged; load 5'h04 returns ram_rdata.
- Debounce (DEB_CYCLES=4, macro defined):
  - gpio_in[0] pulse high 3 cycles -> IN[0] stays 0, EDGE=0.
  - gpio_in[0] held high -> IN[0]=1 exactly 6 cycles after first sampling edge; EDGE[0]=1 same edge.
- Interrupt: IRQ_EN=6'h01 with EDGE[0]=1 -> irq=1 one cycle after the write. W1C writing 1 to EDGE[0] -> EDGE=0, irq=0 one cycle later. W1C writing 0 -> no change.
- Simultaneous set/clear: W1C to EDGE[2] on the cycle deb[2] rises -> EDGE[2] remains 1.
- Macro undefined: gpio_in[1] single-cycle high pulse -> IN[1] high for one cycle 2 cycles later; EDGE[1]=1 and stays set.

Source files
------------

// File: rtl/mmio_gpio_if.sv
// mmio_gpio_if: core data-bus slice seen by the GPIO block.
//   addr      - data address (ALU result low bits)
//   we        - store strobe
//   wdata     - store data
//   ram_rdata - data-RAM read data, passed through on window misses
//   rdata     - load data returned to the core's result mux
// master: core side, slave: mmio_gpio side.
interface mmio_gpio_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output we, output wdata, output ram_rdata, input rdata);
    modport slave  (input addr, input we, input wdata, input ram_rdata, output rdata);
endinterface

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO with registered outputs, synchronised and
// debounced inputs, sticky rising-edge flags (W1C) and a maskable level irq.
//
// Register window (offset = addr[1:0], hit when addr[ADDR_W-1:2] matches BASE):
//   0 OUT    rw  [OUT_W-1:0]
//   1 IN     ro  [IN_W-1:0]   debounced inputs
//   2 EDGE   w1c [IN_W-1:0]   sticky rising-edge flags, set beats clear
//   3 IRQ_EN rw  [IN_W-1:0]
// Loads outside the window return ram_rdata unchanged.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus         - mmio_gpio_if.slave (addr, we, wdata, ram_rdata, rdata)
//   gpio_in_i   - asynchronous inputs
//   gpio_out_o  - registered output pins
//   irq_o       - registered level interrupt, |(EDGE & IRQ_EN)
//
// Build option: define MMIO_GPIO_DEBOUNCE_EN to build the per-input
// debounce counters; without it the accepted input value is the
// synchroniser output and DEB_CYCLES has no effect.

// One input channel: two-flop synchroniser plus optional debouncer.
// rise_o is the 0->1 transition of the accepted value that takes effect
// on the next clock edge, so EDGE sets on the same edge IN updates.
module mmio_gpio_lane #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic deb_o,
    output logic rise_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
        end
    end

`ifdef MMIO_GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Counter runs only while the synchronised value disagrees with the
    // accepted one; any return to agreement restarts qualification.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1))
                deb_d = s2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o  = deb_q;
    assign rise_o = deb_d & ~deb_q;
`else
    localparam int unused_deb_cycles = DEB_CYCLES;

    assign deb_o  = s2_q;
    assign rise_o = s1_q & ~s2_q;
`endif
endmodule

module mmio_gpio #(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 32,
    parameter int                OUT_W      = 4,
    parameter int                IN_W       = 6,
    parameter logic [ADDR_W-1:0] BASE       = 'h1C,
    parameter int                DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    mmio_gpio_if.slave       bus,
    input  logic [IN_W-1:0]  gpio_in_i,
    output logic [OUT_W-1:0] gpio_out_o,
    output logic             irq_o
);
    localparam logic [1:0] OFF_OUT  = 2'd0;
    localparam logic [1:0] OFF_IN   = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_EN   = 2'd3;

    logic [OUT_W-1:0] out_q, out_d, gpio_out_q;
    logic [IN_W-1:0]  edge_q, edge_d, en_q, en_d, clr;
    logic [IN_W-1:0]  deb, rise;
    logic             irq_q, irq_d;
    logic             hit, wr_en;
    logic [1:0]       off;
    logic [DATA_W-1:0] rdata_c;

    // Only the low bits of a store land in registers.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    for (genvar i = 0; i < IN_W; i++) begin : g_lane
        mmio_gpio_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .async_i(gpio_in_i[i]),
            .deb_o  (deb[i]),
            .rise_o (rise[i])
        );
    end

    assign hit   = (bus.addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign off   = bus.addr[1:0];
    assign wr_en = bus.we & hit;

    always_comb begin
        out_d = out_q;
        en_d  = en_q;
        clr   = '0;
        if (wr_en) begin
            case (off)
                OFF_OUT:  out_d = bus.wdata[OUT_W-1:0];
                OFF_EDGE: clr   = bus.wdata[IN_W-1:0];
                OFF_EN:   en_d  = bus.wdata[IN_W-1:0];
                default:  ;
            endcase
        end
        // A new rising edge outranks a clear landing in the same cycle.
        edge_d = (edge_q & ~clr) | rise;
        irq_d  = |(edge_q & en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            gpio_out_q <= '0;
            edge_q     <= '0;
            en_q       <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            gpio_out_q <= out_q;
            edge_q     <= edge_d;
            en_q       <= en_d;
            irq_q      <= irq_d;
        end
    end

    // Zero-cycle load path: window registers on a hit, RAM data otherwise.
    always_comb begin
        rdata_c = bus.ram_rdata;
        if (hit) begin
            case (off)
                OFF_OUT:  rdata_c = DATA_W'(out_q);
                OFF_IN:   rdata_c = DATA_W'(deb);
                OFF_EDGE: rdata_c = DATA_W'(edge_q);
                default:  rdata_c = DATA_W'(en_q);
            endcase
        end
    end

    assign bus.rdata  = rdata_c;
    assign gpio_out_o = gpio_out_q;
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed stimulus with a scoreboard queue. Stimulus pushes
// the expected value of a DUT output; the monitor pops and compares on
// every falling edge, i.e. against the state left by the preceding rising edge.
module tb_mmio_gpio;
    localparam int         AW   = 5;
    localparam int         DW   = 32;
    localparam int         OW   = 4;
    localparam int         IW   = 6;
    localparam int         DEB  = 4;
    localparam logic [4:0] BASE = 5'h1C;
`ifdef MMIO_GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 2;
`endif
    localparam int SEL_RD = 0, SEL_OUT = 1, SEL_IRQ = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] gpio_in = '0;
    logic [OW-1:0] gpio_out;
    logic          irq;

    mmio_gpio_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mmio_gpio #(
        .ADDR_W(AW), .DATA_W(DW), .OUT_W(OW), .IN_W(IW),
        .BASE(BASE), .DEB_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .gpio_in_i (gpio_in),
        .gpio_out_o(gpio_out),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.sel)
                SEL_RD:  act = bus.rdata;
                SEL_OUT: act = 32'(gpio_out);
                default: act = 32'(irq);
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h at %0t", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.we    = 1'b1;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        bus.addr = a;
        bus.we   = 1'b0;
        expect_v(name, SEL_RD, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles while a store to OUT is presented.
        bus.addr      = BASE;
        bus.we        = 1'b1;
        bus.wdata     = 32'hF;
        bus.ram_rdata = 32'hDEAD_BEEF;
        reset         = 1'b1;
        tick();
        expect_v("rst_gpio_out", SEL_OUT, 32'h0);
        expect_v("rst_irq", SEL_IRQ, 32'h0);
        tick();
        reset  = 1'b0;
        bus.we = 1'b0;
        for (int o = 0; o < 4; o++)
            rd(BASE | 5'(o), 32'h0, "rst_read");

        // Output register, read-only IN, out-of-window traffic.
        wr(BASE, 32'hFFFF_FFF5);
        tick();
        expect_v("gpio_out_wr", SEL_OUT, 32'h5);
        rd(BASE, 32'h5, "out_readback");
        wr(BASE | 5'd1, 32'h3F);
        rd(BASE | 5'd1, 32'h0, "in_readonly");
        wr(5'h04, 32'h0);
        tick();
        expect_v("gpio_out_far_wr", SEL_OUT, 32'h5);
        rd(5'h04, 32'hDEAD_BEEF, "ram_passthru");
        wr(BASE | 5'd3, 32'hFFFF_FFFF);
        rd(BASE | 5'd3, 32'h3F, "en_mask_width");
        wr(BASE | 5'd3, 32'h0);

`ifdef MMIO_GPIO_DEBOUNCE_EN
        // Three-cycle glitch must not be accepted.
        gpio_in[0] = 1'b1;
        tick(); tick(); tick();
        gpio_in[0] = 1'b0;
        repeat (LAT + 2) tick();
        rd(BASE | 5'd1, 32'h0, "glitch0_in");
        rd(BASE | 5'd2, 32'h0, "glitch0_edge");
`endif

        // Clean step on input 0: IN rises exactly LAT edges later.
        bus.addr   = BASE | 5'd1;
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) begin
                bus.addr = BASE | 5'd2;
                expect_v("edge_before_lat", SEL_RD, 32'h0);
            end else begin
                bus.addr = BASE | 5'd1;
                expect_v("in_step_latency", SEL_RD, (k == LAT) ? 32'h1 : 32'h0);
            end
        end
        tick();
        bus.addr = BASE | 5'd2;
        expect_v("edge_set", SEL_RD, 32'h1);
        expect_v("irq_masked", SEL_IRQ, 32'h0);
        tick();

        // Enable with pending flag, then W1C of 0 and of 1.
        wr(BASE | 5'd3, 32'h1);
        expect_v("irq_en_edge", SEL_IRQ, 32'h0);
        tick();
        expect_v("irq_en_rise", SEL_IRQ, 32'h1);
        tick();
        wr(BASE | 5'd2, 32'h0);
        expect_v("irq_w1c0", SEL_IRQ, 32'h1);
        rd(BASE | 5'd2, 32'h1, "edge_w1c0");
        wr(BASE | 5'd2, 32'h1);
        expect_v("irq_w1c_edge", SEL_IRQ, 32'h1);
        tick();
        expect_v("irq_w1c_drop", SEL_IRQ, 32'h0);
        rd(BASE | 5'd2, 32'h0, "edge_w1c1");

        // Clear of EDGE[2] lands on the same edge it sets: set wins.
        gpio_in[2] = 1'b1;
        for (int k = 1; k < LAT; k++) tick();
        wr(BASE | 5'd2, 32'h4);
        expect_v("irq_bit2_masked", SEL_IRQ, 32'h0);
        rd(BASE | 5'd2, 32'h4, "set_wins");
        wr(BASE | 5'd3, 32'h4);
        tick();
        expect_v("irq_bit2", SEL_IRQ, 32'h1);
        wr(BASE | 5'd2, 32'h4);
        tick();
        expect_v("irq_bit2_clr", SEL_IRQ, 32'h0);
        rd(BASE | 5'd2, 32'h0, "edge_bit2_clr");
        rd(BASE | 5'd1, 32'h5, "in_bits_0_2");

        // Short pulse on input 1.
        bus.addr = BASE | 5'd1;
`ifdef MMIO_GPIO_DEBOUNCE_EN
        gpio_in[1] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k == 3) gpio_in[1] = 1'b0;
            expect_v("glitch1_in", SEL_RD, 32'h5);
        end
        tick();
        rd(BASE | 5'd2, 32'h0, "glitch1_edge");
`else
        gpio_in[1] = 1'b1;
        tick();
        gpio_in[1] = 1'b0;
        expect_v("pulse1_in_pre", SEL_RD, 32'h5);
        tick();
        expect_v("pulse1_in_high", SEL_RD, 32'h7);
        tick();
        expect_v("pulse1_in_low", SEL_RD, 32'h5);
        tick();
        bus.addr = BASE | 5'd2;
        expect_v("pulse1_edge", SEL_RD, 32'h2);
        tick();
        expect_v("pulse1_edge_sticky", SEL_RD, 32'h2);
        tick();
`endif

        // Reset during qualification of input 3; all inputs re-qualify after.
        gpio_in[3] = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        bus.addr = BASE | 5'd1;
        expect_v("rst2_in", SEL_RD, 32'h0);
        expect_v("rst2_gpio_out", SEL_OUT, 32'h0);
        expect_v("rst2_irq", SEL_IRQ, 32'h0);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            expect_v("requal_in", SEL_RD, (k == LAT) ? 32'hD : 32'h0);
        end
        tick();
        rd(BASE | 5'd2, 32'hD, "requal_edge");

        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
